// File: rtl/data_mem_arb_pkg.sv
// Shared defaults and FSM state encoding for the two-port data memory arbiter.
package data_mem_arb_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;
    localparam int STAT_W     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/data_mem_arb_stats.sv
// Per-port accept counters, 16-bit, saturating at all-ones.
module data_mem_arb_stats
    import data_mem_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            i_inc,
    output logic [2*STAT_W-1:0]   o_cnt
);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [STAT_W-1:0] r_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (i_inc[gi] && (r_cnt != {STAT_W{1'b1}})) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign o_cnt[gi*STAT_W +: STAT_W] = r_cnt;
        end
    endgenerate

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter with bounded burst ownership in front of a 512x32 data memory.
// Optional accept counters are built when DATA_MEM_ARB_STATS_EN is defined.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [STAT_W-1:0] stat_gnt0,
    output logic [STAT_W-1:0] stat_gnt1
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t        r_state;
    logic              r_rr_ptr;
    logic [CNT_W-1:0]  r_burst_cnt;
    logic              r_rsp0_valid;
    logic              r_rsp1_valid;
    logic [DATA_W-1:0] r_rsp0_rdata;
    logic [DATA_W-1:0] r_rsp1_rdata;
    logic [ADDR_W-1:0] r_raddr_hold;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_acc0;
    logic              w_acc1;
    logic              w_acc_any;
    logic              w_under_max;
    logic              w_win_we;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_wdata;

    assign w_under_max = (r_burst_cnt < CNT_W'(MAX_BURST));

    // The owner keeps the port while under its burst budget or while the other side is idle.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        case (r_state)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    w_gnt0 = ~r_rr_ptr;
                    w_gnt1 = r_rr_ptr;
                end else begin
                    w_gnt0 = req0_valid;
                    w_gnt1 = req1_valid;
                end
            end
            OWN0: begin
                if (req0_valid && (w_under_max || !req1_valid)) w_gnt0 = 1'b1;
                else if (req1_valid)                           w_gnt1 = 1'b1;
            end
            OWN1: begin
                if (req1_valid && (w_under_max || !req0_valid)) w_gnt1 = 1'b1;
                else if (req0_valid)                           w_gnt0 = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_acc0    = w_gnt0 & rst_n;
    assign w_acc1    = w_gnt1 & rst_n;
    assign w_acc_any = w_acc0 | w_acc1;

    assign w_win_we    = w_gnt1 ? req1_we    : req0_we;
    assign w_win_addr  = w_gnt1 ? req1_addr  : req0_addr;
    assign w_win_wdata = w_gnt1 ? req1_wdata : req0_wdata;

    assign req0_ready = w_acc0;
    assign req1_ready = w_acc1;
    assign mem_we     = w_acc_any & w_win_we;
    assign mem_waddr  = w_win_addr;
    assign mem_wdata  = w_win_wdata;
    assign mem_raddr  = w_acc_any ? w_win_addr : r_raddr_hold;

    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp0_rdata = r_rsp0_rdata;
    assign rsp1_rdata = r_rsp1_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_rr_ptr     <= 1'b0;
            r_burst_cnt  <= '0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_rdata <= '0;
            r_rsp1_rdata <= '0;
            r_raddr_hold <= '0;
        end else begin
            r_rsp0_valid <= w_acc0 & ~req0_we;
            r_rsp1_valid <= w_acc1 & ~req1_we;
            if (w_acc0 && !req0_we) r_rsp0_rdata <= mem_rdata;
            if (w_acc1 && !req1_we) r_rsp1_rdata <= mem_rdata;
            if (w_acc_any)          r_raddr_hold <= w_win_addr;

            if (w_acc0) begin
                if (r_state == OWN0) begin
                    if (w_under_max) r_burst_cnt <= r_burst_cnt + 1'b1;
                end else begin
                    r_state     <= OWN0;
                    r_burst_cnt <= CNT_W'(1);
                    r_rr_ptr    <= 1'b1;
                end
            end else if (w_acc1) begin
                if (r_state == OWN1) begin
                    if (w_under_max) r_burst_cnt <= r_burst_cnt + 1'b1;
                end else begin
                    r_state     <= OWN1;
                    r_burst_cnt <= CNT_W'(1);
                    r_rr_ptr    <= 1'b0;
                end
            end else begin
                r_state     <= IDLE;
                r_burst_cnt <= '0;
            end
        end
    end

`ifdef DATA_MEM_ARB_STATS_EN
    logic [2*STAT_W-1:0] w_stat_cnt;

    data_mem_arb_stats u_stats (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc ({w_acc1, w_acc0}),
        .o_cnt (w_stat_cnt)
    );

    assign stat_gnt0 = w_stat_cnt[STAT_W-1:0];
    assign stat_gnt1 = w_stat_cnt[2*STAT_W-1:STAT_W];
`else
    assign stat_gnt0 = '0;
    assign stat_gnt1 = '0;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural 512x32 memory attached.
module tb_data_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_we, req0_ready;
    logic [8:0]  req0_addr;
    logic [31:0] req0_wdata;
    logic        req1_valid, req1_we, req1_ready;
    logic [8:0]  req1_addr;
    logic [31:0] req1_wdata;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        mem_we;
    logic [8:0]  mem_waddr, mem_raddr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [15:0] stat_gnt0, stat_gnt1;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem_array [0:511];

    always @(posedge clk) begin
        if (mem_we) mem_array[mem_waddr] <= mem_wdata;
    end
    assign mem_rdata = mem_array[mem_raddr];

    data_mem_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_ready (req1_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .stat_gnt0  (stat_gnt0),
        .stat_gnt1  (stat_gnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst_n      = 1'b0;
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 9'h040; req0_wdata = 32'h1111_2222;
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 9'h041; req1_wdata = 32'h3333_4444;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL reset_ready0 got=%b want=0", req0_ready); end
        total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL reset_ready1 got=%b want=0", req1_ready); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%b want=0", mem_we); end
        total++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b%b want=00", rsp0_valid, rsp1_valid); end
        total++; if (rsp0_rdata !== 32'h0 || rsp1_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata got=%h/%h want=0/0", rsp0_rdata, rsp1_rdata); end
        total++; if (stat_gnt0 !== 16'h0 || stat_gnt1 !== 16'h0) begin bad++; $display("FAIL reset_stats got=%h/%h want=0/0", stat_gnt0, stat_gnt1); end
        $display("[reset] held low with both ports requesting");
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n      = 1'b1;
    endtask

    task automatic test_round_robin;
        logic exp0;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 9'h020;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 9'h030;
        for (int i = 0; i < 12; i++) begin
            exp0 = (((i / 4) % 2) == 0);
            @(negedge clk);
            total++;
            if (req0_ready !== exp0 || req1_ready !== !exp0) begin
                bad++;
                $display("FAIL rr_grant[%0d] got=%b%b want=%b%b", i, req0_ready, req1_ready, exp0, !exp0);
            end
            $display("[rr] cycle %0d ready0=%b ready1=%b", i, req0_ready, req1_ready);
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_write_read;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 9'h010; req0_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        total++; if (req0_ready !== 1'b1 || mem_we !== 1'b1) begin bad++; $display("FAIL wr_accept got ready=%b we=%b want 1/1", req0_ready, mem_we); end
        total++; if (mem_waddr !== 9'h010 || mem_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_bus got=%h/%h want=010/deadbeef", mem_waddr, mem_wdata); end
        $display("[wr] port0 write 0x010 <= deadbeef");
        @(posedge clk); #1;
        req0_we = 1'b0;
        @(negedge clk);
        total++; if (req0_ready !== 1'b1 || mem_we !== 1'b0 || mem_raddr !== 9'h010) begin bad++; $display("FAIL rd_accept got ready=%b we=%b raddr=%h want 1/0/010", req0_ready, mem_we, mem_raddr); end
        total++; if (rsp0_valid !== 1'b0) begin bad++; $display("FAIL wr_no_rsp got=%b want=0", rsp0_valid); end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        total++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_rsp got=%b/%h want=1/deadbeef", rsp0_valid, rsp0_rdata); end
        $display("[rd] port0 read 0x010 -> %h", rsp0_rdata);
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (rsp0_valid !== 1'b0) begin bad++; $display("FAIL rd_rsp_pulse got=%b want=0", rsp0_valid); end
    endtask

    task automatic test_port1_burst;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 9'(i); req1_wdata = 32'hC0DE_0000 + 32'(i);
            @(negedge clk);
            total++; if (req1_ready !== 1'b1 || mem_we !== 1'b1) begin bad++; $display("FAIL p1_wr[%0d] got ready=%b we=%b want 1/1", i, req1_ready, mem_we); end
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            req1_we = 1'b0; req1_addr = 9'(i);
            @(negedge clk);
            total++; if (req1_ready !== 1'b1 || mem_raddr !== 9'(i)) begin bad++; $display("FAIL p1_rd[%0d] got ready=%b raddr=%h want 1/%h", i, req1_ready, mem_raddr, 9'(i)); end
            if (i == 0) begin
                total++; if (rsp1_valid !== 1'b0) begin bad++; $display("FAIL p1_rsp_first got=%b want=0", rsp1_valid); end
            end else begin
                total++;
                if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'hC0DE_0000 + 32'(i - 1)) begin
                    bad++;
                    $display("FAIL p1_rsp[%0d] got=%b/%h want=1/%h", i - 1, rsp1_valid, rsp1_rdata, 32'hC0DE_0000 + 32'(i - 1));
                end
                $display("[p1] rsp %0d data=%h", i - 1, rsp1_rdata);
            end
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk);
        total++; if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'hC0DE_0007) begin bad++; $display("FAIL p1_rsp[7] got=%b/%h want=1/c0de0007", rsp1_valid, rsp1_rdata); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (rsp1_valid !== 1'b0) begin bad++; $display("FAIL p1_rsp_end got=%b want=0", rsp1_valid); end
    endtask

    task automatic test_owner_drop;
        logic exp1 [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 9'h010;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 9'h005;
        @(negedge clk);
        total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL drop_a got=%b%b want=10", req0_ready, req1_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL drop_b got=%b%b want=10", req0_ready, req1_ready); end
        total++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL drop_rsp0 got=%b/%h want=1/deadbeef", rsp0_valid, rsp0_rdata); end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin bad++; $display("FAIL drop_c got=%b%b want=01", req0_ready, req1_ready); end
        $display("[drop] port0 released after 2 accepts, port1 granted");
        @(posedge clk); #1;
        req0_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (req1_ready !== exp1[i] || req0_ready !== !exp1[i]) begin
                bad++;
                $display("FAIL drop_burst[%0d] got=%b%b want=%b%b", i, req0_ready, req1_ready, !exp1[i], exp1[i]);
            end
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_burst;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 9'h010;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 9'h005;
        @(negedge clk);
        total++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin bad++; $display("FAIL mid_first got=%b%b want=01", req0_ready, req1_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL mid_second got=%b want=1", req1_ready); end
        @(posedge clk); #1;
        total++; if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'hC0DE_0005) begin bad++; $display("FAIL mid_rsp got=%b/%h want=1/c0de0005", rsp1_valid, rsp1_rdata); end
        req0_we = 1'b1; req0_addr = 9'h040; req0_wdata = 32'hAAAA_0040;
        req1_we = 1'b1; req1_addr = 9'h041; req1_wdata = 32'hBBBB_0041;
        rst_n = 1'b0;
        #1;
        total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL mid_gate got=%b%b we=%b want=00/0", req0_ready, req1_ready, mem_we); end
        total++; if (rsp1_valid !== 1'b0 || rsp1_rdata !== 32'h0) begin bad++; $display("FAIL mid_rsp_drop got=%b/%h want=0/0", rsp1_valid, rsp1_rdata); end
        total++; if (stat_gnt0 !== 16'h0 || stat_gnt1 !== 16'h0) begin bad++; $display("FAIL mid_stats got=%h/%h want=0/0", stat_gnt0, stat_gnt1); end
        $display("[mid] reset asserted during port1 burst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL mid_restart got=%b%b want=10", req0_ready, req1_ready); end
        total++; if (mem_we !== 1'b1 || mem_waddr !== 9'h040) begin bad++; $display("FAIL mid_restart_wr got we=%b addr=%h want 1/040", mem_we, mem_waddr); end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_stats;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 9'h000;
`ifdef DATA_MEM_ARB_STATS_EN
        repeat (70000) @(posedge clk);
        #1;
        req0_valid = 1'b0;
        @(negedge clk);
        total++; if (stat_gnt0 !== 16'hFFFF) begin bad++; $display("FAIL stat_sat0 got=%h want=ffff", stat_gnt0); end
        total++; if (stat_gnt1 !== 16'h0000) begin bad++; $display("FAIL stat_gnt1 got=%h want=0000", stat_gnt1); end
`else
        repeat (3) @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 9'h001;
        repeat (2) @(posedge clk);
        #1;
        req1_valid = 1'b0;
        @(negedge clk);
        total++; if (stat_gnt0 !== 16'h0 || stat_gnt1 !== 16'h0) begin bad++; $display("FAIL stat_off got=%h/%h want=0/0", stat_gnt0, stat_gnt1); end
`endif
        $display("[stats] stat_gnt0=%h stat_gnt1=%h", stat_gnt0, stat_gnt1);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_write_read();
        test_port1_burst();
        test_owner_drop();
        test_reset_mid_burst();
        test_stats();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
